shake_dump_stage: RTL and testbench

Parametrised output ("dump") stage of the SHAKE core, sitting after the squeeze/permutation stage. It accepts one rate-sized output block per load, in parallel, and streams it out as `DATA_W`-bit words over a valid/ready handshake. It supports both SHAKE128 and SHAKE256 rates, trims the final block to a byte-exact length with a byte-keep mask, and flags protocol violations from upstream.

---
 rtl/shake_dump_pkg.sv | 43 ++++
 rtl/shake_dump_buffer.sv | 28 ++
 rtl/shake_dump_stage.sv | 150 +++++++++++++++
 tb/tb_shake_dump_stage.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shake_dump_pkg.sv
// Purpose: shared types, rate constants and word-count/keep helper for the SHAKE dump stage.
// Latency: n/a (combinational helper only).
// Backpressure: n/a.
package shake_dump_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  typedef enum logic {
    SHAKE128 = 1'b0,
    SHAKE256 = 1'b1
  } mode_t;

  localparam int RATE128_BYTES = 168;
  localparam int RATE256_BYTES = 136;

  // Per-block drain descriptor captured at load time.
  typedef struct packed {
    logic       last;   // block is the final block of the digest
    logic [7:0] cnt;    // words to emit
    logic [7:0] keep;   // byte mask for the final word (low word_bytes bits used)
  } blk_info_t;

  // Map mode and requested byte count to a word count and a final-word keep mask.
  // Non-last blocks, N=0 and N above the rate all drain the full rate.
  function automatic blk_info_t dump_calc(mode_t m, logic last, logic [7:0] n, int word_bytes);
    blk_info_t r;
    int        rate;
    int        eff;
    int        rem;
    rate = (m == SHAKE256) ? RATE256_BYTES : RATE128_BYTES;
    eff  = rate;
    if (last && (n != 8'd0) && (int'(n) <= rate)) eff = int'(n);
    rem    = eff % word_bytes;
    r.last = last;
    r.cnt  = 8'((eff + word_bytes - 1) / word_bytes);
    r.keep = (rem == 0) ? 8'((1 << word_bytes) - 1) : 8'((1 << rem) - 1);
    return r;
  endfunction

endpackage

// File: rtl/shake_dump_buffer.sv
// Purpose: parallel-load block register that shifts right by one output word per step.
// Latency: load/shift visible one cycle after the strobe.
// Backpressure: none internally; the owner only strobes i_shift on an accepted word.
module shake_dump_buffer #(
  parameter int W      = 1344,
  parameter int DATA_W = 64,
  parameter int OUT_W  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [W-1:0]     i_dat,
  output logic [OUT_W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Load wins over shift; a shift exposes the next word at the bottom.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_q <= '0;
    else if (i_load)  r_q <= i_dat;
    else if (i_shift) r_q <= r_q >> DATA_W;
  end

  assign o_q = r_q[OUT_W-1:0];

endmodule

// File: rtl/shake_dump_stage.sv
// Purpose: streams a rate-sized SHAKE output block as DATA_W words with byte keep and last; optional shadow register via SHAKE_DUMP_DOUBLE_BUFFER_EN.
// Latency: load at t gives word 0 at t+1, then one word per cycle while ready_in=1.
// Backpressure: words hold stable while ready_in=0; loads while unavailable are dropped and set sticky overflow_err.
module shake_dump_stage
  import shake_dump_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int MAX_RATE_W = 1344
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [MAX_RATE_W-1:0] block_in,
  input  logic                  block_we_in,
  input  logic                  last_block_in,
  input  logic [7:0]            last_bytes_in,
  output logic                  output_buffer_available_wr,
  output logic [DATA_W-1:0]     data_out,
  output logic [DATA_W/8-1:0]   keep_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  last_out,
  output logic                  overflow_err
);

  localparam int KW = DATA_W / 8;

  state_t                r_state, w_state_nxt;
  logic [7:0]            r_cnt;
  logic [7:0]            r_keep_fin;
  logic                  r_last;
  logic                  r_ovf;
  logic                  w_avail, w_accept, w_hs, w_final;
  logic                  w_load_direct, w_promote, w_load_main;
  blk_info_t             w_new_info, w_load_info;
  logic [MAX_RATE_W-1:0] w_load_dat;
  logic [DATA_W-1:0]     w_word;

  assign w_new_info = dump_calc(mode_t'(mode), last_block_in, last_bytes_in, KW);
  assign w_hs       = (r_state == DRAIN) && ready_in;
  assign w_final    = w_hs && (r_cnt == 8'd1);
  assign w_accept   = block_we_in && w_avail;

`ifdef SHAKE_DUMP_DOUBLE_BUFFER_EN
  logic                  r_sh_full;
  blk_info_t             r_sh_info;
  logic [MAX_RATE_W-1:0] w_sh_q;
  logic                  w_park;

  // A load that lands on the final handshake with an empty shadow goes straight to the drain buffer.
  assign w_avail       = !r_sh_full;
  assign w_promote     = w_final && r_sh_full;
  assign w_load_direct = w_accept && ((r_state == IDLE) || (w_final && !r_sh_full));
  assign w_park        = w_accept && !w_load_direct;
  assign w_load_dat    = w_promote ? w_sh_q : block_in;
  assign w_load_info   = w_promote ? r_sh_info : w_new_info;

  shake_dump_buffer #(.W(MAX_RATE_W), .DATA_W(DATA_W), .OUT_W(MAX_RATE_W)) u_shadow (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_park),
    .i_shift (1'b0),
    .i_dat   (block_in),
    .o_q     (w_sh_q)
  );

  // Track shadow occupancy and its descriptor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_full <= 1'b0;
      r_sh_info <= '0;
    end else if (w_park) begin
      r_sh_full <= 1'b1;
      r_sh_info <= w_new_info;
    end else if (w_promote) begin
      r_sh_full <= 1'b0;
    end
  end
`else
  assign w_avail       = (r_state == IDLE);
  assign w_promote     = 1'b0;
  assign w_load_direct = w_accept;
  assign w_load_dat    = block_in;
  assign w_load_info   = w_new_info;
`endif

  assign w_load_main = w_load_direct || w_promote;

  shake_dump_buffer #(.W(MAX_RATE_W), .DATA_W(DATA_W), .OUT_W(DATA_W)) u_drain (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load_main),
    .i_shift (w_hs && !w_final),
    .i_dat   (w_load_dat),
    .o_q     (w_word)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and output decode; outputs are zero outside DRAIN.
  always_comb begin
    w_state_nxt = r_state;
    valid_out   = 1'b0;
    data_out    = '0;
    keep_out    = '0;
    last_out    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_load_main) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        valid_out = 1'b1;
        data_out  = w_word;
        keep_out  = (r_cnt == 8'd1) ? r_keep_fin[KW-1:0] : '1;
        last_out  = r_last && (r_cnt == 8'd1);
        if (w_final && !w_load_main) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Word counter and final-word descriptor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_keep_fin <= '0;
      r_last     <= 1'b0;
    end else if (w_load_main) begin
      r_cnt      <= w_load_info.cnt;
      r_keep_fin <= w_load_info.keep;
      r_last     <= w_load_info.last;
    end else if (w_hs) begin
      r_cnt      <= r_cnt - 8'd1;
    end
  end

  // Sticky flag for loads arriving while the stage cannot take them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_ovf <= 1'b0;
    else if (block_we_in && !w_avail) r_ovf <= 1'b1;
  end

  assign output_buffer_available_wr = w_avail;
  assign overflow_err               = r_ovf;

endmodule

// File: tb/tb_shake_dump_stage.sv
// Purpose: randomized self-checking bench for shake_dump_stage against a byte-level reference queue.
// Latency: n/a.
// Backpressure: drives random ready_in; SHAKE_DUMP_DOUBLE_BUFFER_EN selects the shadow-register expectations.
module tb_shake_dump_stage;

  localparam int W  = 64;
  localparam int KB = W / 8;
  localparam int RW = 1344;
`ifdef SHAKE_DUMP_DOUBLE_BUFFER_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mode = 1'b0;
  logic [RW-1:0] block_in = '0;
  logic          block_we_in = 1'b0;
  logic          last_block_in = 1'b0;
  logic [7:0]    last_bytes_in = 8'd0;
  logic          output_buffer_available_wr;
  logic [W-1:0]  data_out;
  logic [KB-1:0] keep_out;
  logic          valid_out;
  logic          ready_in = 1'b0;
  logic          last_out;
  logic          overflow_err;

  shake_dump_stage #(.DATA_W(W), .MAX_RATE_W(RW)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .mode                       (mode),
    .block_in                   (block_in),
    .block_we_in                (block_we_in),
    .last_block_in              (last_block_in),
    .last_bytes_in              (last_bytes_in),
    .output_buffer_available_wr (output_buffer_available_wr),
    .data_out                   (data_out),
    .keep_out                   (keep_out),
    .valid_out                  (valid_out),
    .ready_in                   (ready_in),
    .last_out                   (last_out),
    .overflow_err               (overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  d;
    logic [KB-1:0] k;
    bit            l;
    bit            e;
  } word_t;

  word_t q[$];
  int    pend = 0;
  bit    m_ovf = 1'b0;
  int    vectors = 0;
  int    miscompares = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_avail();
    return DBL ? (pend < 2) : (pend == 0);
  endfunction

  // Expand the presented block into its expected word stream by counting bytes.
  task automatic push_block();
    int    rate, n, nw, vb;
    word_t w;
    rate = mode ? 136 : 168;
    n    = rate;
    if (last_block_in && last_bytes_in != 8'd0 && int'(last_bytes_in) <= rate) n = int'(last_bytes_in);
    nw = (n + KB - 1) / KB;
    for (int i = 0; i < nw; i++) begin
      vb = n - i * KB;
      if (vb > KB) vb = KB;
      w.d = block_in[i*W +: W];
      w.k = KB'((1 << vb) - 1);
      w.l = last_block_in && (i == nw - 1);
      w.e = (i == nw - 1);
      q.push_back(w);
    end
    pend++;
  endtask

  // Reference model: word queue advances on accepted words, grows on accepted loads.
  always @(posedge clk or posedge rst) begin
    bit av;
    if (rst) begin
      q.delete();
      pend  = 0;
      m_ovf = 1'b0;
    end else begin
      av = m_avail();
      if (block_we_in && !av) m_ovf = 1'b1;
      if (q.size() > 0 && ready_in) begin
        if (q[0].e) pend--;
        void'(q.pop_front());
      end
      if (block_we_in && av) push_block();
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      chk("valid_out", W'(valid_out), W'(1));
      chk("data_out", data_out, q[0].d);
      chk("keep_out", W'(keep_out), W'(q[0].k));
      chk("last_out", W'(last_out), W'(q[0].l));
    end else begin
      chk("valid_out_idle", W'(valid_out), W'(0));
      chk("data_out_idle", data_out, '0);
      chk("keep_out_idle", W'(keep_out), W'(0));
      chk("last_out_idle", W'(last_out), W'(0));
    end
    chk("avail", W'(output_buffer_available_wr), W'(m_avail()));
    chk("overflow_err", W'(overflow_err), W'(m_ovf));
  end

  int            hs_cnt, vcyc, last_cnt, last_idx;
  logic [KB-1:0] last_keep, first_keep;

  task automatic clr_obs();
    hs_cnt = 0; vcyc = 0; last_cnt = 0; last_idx = -1; last_keep = '0; first_keep = '0;
  endtask

  task automatic cyc(input bit we, input bit rdy);
    block_we_in = we;
    ready_in    = rdy;
    @(negedge clk);
    if (valid_out) vcyc++;
    if (valid_out && ready_in) begin
      if (hs_cnt == 0) first_keep = keep_out;
      if (last_out) begin
        last_cnt++;
        last_idx  = hs_cnt;
        last_keep = keep_out;
      end
      hs_cnt++;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic set_blk(input bit md, input bit lst, input logic [7:0] lb);
    for (int i = 0; i < RW / 32; i++) block_in[i*32 +: 32] = $urandom;
    mode          = md;
    last_block_in = lst;
    last_bytes_in = lb;
  endtask

  task automatic drain(input int pct);
    int n;
    n = 0;
    while ((q.size() > 0) && (n < 2000)) begin
      cyc(1'b0, $urandom_range(99) < pct);
      n++;
    end
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d words left, required 0", q.size());
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", W'(valid_out), W'(0));
    chk("rst_avail", W'(output_buffer_available_wr), W'(1));
    chk("rst_data", data_out, '0);
    chk("rst_keep", W'(keep_out), W'(0));
    chk("rst_last", W'(last_out), W'(0));
    chk("rst_ovf", W'(overflow_err), W'(0));
    rst = 1'b0;
    cyc(1'b0, 1'b1);

    // SHAKE128 non-last block at full throughput.
    set_blk(1'b0, 1'b0, 8'd0); clr_obs(); cyc(1'b1, 1'b1); drain(100);
    chk("s128_words", W'(hs_cnt), W'(21));
    chk("s128_cycles", W'(vcyc), W'(21));
    chk("s128_keep", W'(first_keep), W'(8'hFF));
    chk("s128_nolast", W'(last_cnt), W'(0));
    chk("s128_avail_after", W'(output_buffer_available_wr), W'(1));

    // SHAKE256 last block, N=32 then N=13.
    set_blk(1'b1, 1'b1, 8'd32); clr_obs(); cyc(1'b1, 1'b1); drain(100);
    chk("n32_words", W'(hs_cnt), W'(4));
    chk("n32_last_idx", W'(last_idx), W'(3));
    chk("n32_keep", W'(last_keep), W'(8'hFF));
    set_blk(1'b1, 1'b1, 8'd13); clr_obs(); cyc(1'b1, 1'b1); drain(100);
    chk("n13_words", W'(hs_cnt), W'(2));
    chk("n13_keep", W'(last_keep), W'(8'h1F));

    // Backpressured SHAKE128 block.
    set_blk(1'b0, 1'b1, 8'd0); clr_obs(); cyc(1'b1, 1'b0); drain(50);
    chk("bp_words", W'(hs_cnt), W'(21));

    // Second load while draining (100-byte last block, then a SHAKE256 block).
    set_blk(1'b0, 1'b1, 8'd100); clr_obs(); cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1); cyc(1'b0, 1'b1);
    set_blk(1'b1, 1'b0, 8'd0); cyc(1'b1, 1'b1); drain(100);
    if (DBL) begin
      chk("dbl_words", W'(hs_cnt), W'(30));
      chk("dbl_no_bubble", W'(vcyc), W'(30));
      chk("dbl_ovf", W'(overflow_err), W'(0));
    end else begin
      chk("ovf_words", W'(hs_cnt), W'(13));
      chk("ovf_set", W'(overflow_err), W'(1));
      repeat (3) cyc(1'b0, 1'b1);
      chk("ovf_sticky", W'(overflow_err), W'(1));
    end

    // Reset in the middle of a drain.
    set_blk(1'b0, 1'b0, 8'd0); clr_obs(); cyc(1'b1, 1'b1);
    for (int i = 0; i < 100 && hs_cnt < 10; i++) cyc(1'b0, 1'b1);
    chk("pre_rst_words", W'(hs_cnt), W'(10));
    rst = 1'b1;
    #1;
    chk("midrst_valid", W'(valid_out), W'(0));
    chk("midrst_data", data_out, '0);
    chk("midrst_avail", W'(output_buffer_available_wr), W'(1));
    chk("midrst_ovf", W'(overflow_err), W'(0));
    @(posedge clk); #2;
    rst = 1'b0;
    set_blk(1'b0, 1'b1, 8'd0); clr_obs(); cyc(1'b1, 1'b1); drain(100);
    chk("post_rst_words", W'(hs_cnt), W'(21));
    chk("post_rst_last", W'(last_cnt), W'(1));
    chk("post_rst_keep", W'(last_keep), W'(8'hFF));

    // Random traffic: random modes, lengths (incl. 0 and above rate), loads and backpressure.
    for (int i = 0; i < 1500; i++) begin
      bit we;
      we = ($urandom_range(5) == 0);
      if (we) set_blk(1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom_range(255)));
      cyc(we, $urandom_range(99) < 70);
    end
    drain(100);
    cyc(1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
